// File: rtl/mult_seq_32b.sv
// mult_seq_32b: iterative shift-add multiplier feeding the HI/LO pair.
// One add of the partial product and the multiplicand per cycle,
// followed by a one-bit right shift of {carry, sum, lo}. After W
// iterations the full 2W-bit product is held in {hi, lo}.
//
// Optional feature (macro MULT_SIGNED_EN): adds the is_signed port.
// Signed ops multiply absolute values and then two's-complement the
// product in a FIX state when the operand signs differ.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, accepted when busy=0 (IDLE or DONE)
//   a, b       multiplicand / multiplier, captured on accept
//   is_signed  1 = mult, 0 = multu (MULT_SIGNED_EN only)
//   busy       operation in progress (RUN or FIX)
//   done       one-cycle pulse, hi/lo valid from this cycle on
//   hi, lo     upper / lower product word
module mult_seq_32b #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef MULT_SIGNED_EN
    input  logic         is_signed,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef MULT_SIGNED_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mcand;
    logic [W:0]     sum;
    logic           accept;
    logic [W-1:0]   a_ld, b_ld;

`ifdef MULT_SIGNED_EN
    logic           sgn_op;
    logic           neg;
    logic [2*W-1:0] prod_neg;

    // |0x80..0| stays 0x80..0, which read as unsigned is exactly 2^(W-1).
    assign a_ld     = (is_signed && a[W-1]) ? (~a + W'(1)) : a;
    assign b_ld     = (is_signed && b[W-1]) ? (~b + W'(1)) : b;
    assign prod_neg = ~{hi, lo} + (2*W)'(1);
`else
    assign a_ld = a;
    assign b_ld = b;
`endif

    assign accept = start && (state == S_IDLE || state == S_DONE);
    // 33-bit sum keeps the carry, which becomes hi[W-1] after the shift.
    assign sum    = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};

`ifdef MULT_SIGNED_EN
    assign busy = (state == S_RUN) || (state == S_FIX);
`else
    assign busy = (state == S_RUN);
`endif
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (cnt == CW'(W-1)) begin
`ifdef MULT_SIGNED_EN
                    state_nxt = sgn_op ? S_FIX : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            S_FIX:  state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULT_SIGNED_EN
            sgn_op <= 1'b0;
            neg    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand  <= a_ld;
                lo     <= b_ld;
                hi     <= '0;
                cnt    <= '0;
`ifdef MULT_SIGNED_EN
                sgn_op <= is_signed;
                neg    <= is_signed & (a[W-1] ^ b[W-1]);
`endif
            end else begin
                case (state)
                    S_RUN: begin
                        {hi, lo} <= {sum, lo[W-1:1]};
                        cnt      <= cnt + CW'(1);
                    end
`ifdef MULT_SIGNED_EN
                    S_FIX: if (neg) {hi, lo} <= prod_neg;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mult_seq_32b.sv
// Directed bench for mult_seq_32b with hand-computed products.
// Signed vectors run only when MULT_SIGNED_EN is defined.
module tb_mult_seq_32b;
    logic        clk, rst, start;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;
`ifdef MULT_SIGNED_EN
    logic        is_signed;
`endif
    int n_checks = 0;
    int n_errors = 0;

    mult_seq_32b #(.W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef MULT_SIGNED_EN
        .is_signed(is_signed),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request and return just after the accepting edge (edge 0).
    task automatic go(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen at a
    // negedge. rp >= 0 re-pulses start with junk operands at that cycle.
    task automatic wait_done(input int rp, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            if (lat == rp) begin a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1; end
            if (lat > 40) begin chk("timeout", 64'd1, 64'd0); break; end
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int exp_lat);
        int lat, bcnt;
        go(x, y);
        wait_done(-1, lat, bcnt);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, {hi, lo}, exp);
    endtask

    initial begin
        int lat, bcnt, ndone;
        start = 1'b0; a = '0; b = '0;
`ifdef MULT_SIGNED_EN
        is_signed = 1'b0;
`endif
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // small unsigned with latency and busy length
        go(32'd3, 32'd5);
        wait_done(-1, lat, bcnt);
        chk("small_lat", 64'(lat), 64'd32);
        chk("small_busy", 64'(bcnt), 64'd32);
        chk("small_prod", {hi, lo}, 64'h0000_0000_0000_000F);

        // hold through IDLE
        repeat (3) @(negedge clk);
        chk("hold_prod", {hi, lo}, 64'h0000_0000_0000_000F);
        chk("idle_busy", 64'(busy), 64'd0);

        run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        run("x2", 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 32);
        run("p32", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 32);
        run("umin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32);
        run("zero", 32'd0, 32'hFFFF_FFFF, 64'd0, 32);

`ifdef MULT_SIGNED_EN
        is_signed = 1'b1;
        run("sneg", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33);
        run("smin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        run("spos", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 33);
        is_signed = 1'b0;
        run("uns_on", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
`endif

        // ignored start at cycle 10, exactly one done
        go(32'd3, 32'd5);
        wait_done(10, lat, bcnt);
        chk("ign_lat", 64'(lat), 64'd32);
        chk("ign_prod", {hi, lo}, 64'h0000_0000_0000_000F);
        ndone = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ign_one_done", 64'(ndone), 64'd0);

        // back-to-back: start during done cycle
        go(32'd3, 32'd5);
        wait_done(-1, lat, bcnt);
        chk("b2b_lo1", 64'(lo), 64'd15);
        a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        wait_done(-1, lat, bcnt);
        chk("b2b_lat", 64'(lat + 1), 64'd32);
        chk("b2b_prod", {hi, lo}, 64'd42);

        // reset mid-op
        go(32'd3, 32'd5);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_prod", {hi, lo}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_nodone", 64'(ndone), 64'd0);
        rst = 1'b0;
        run("after_rst", 32'd2, 32'd2, 64'd4, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
